// File: rtl/fetch_branch_unit_if.sv
// rtl/fetch_branch_unit_if.sv - instruction memory req/ack fetch bus
interface fetch_branch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_branch_unit.sv
// rtl/fetch_branch_unit.sv - PC owner: fetch over req/ack, hold E/GT flags, resolve next PC
module fetch_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          OFFSET_W = 27
) (
  input  logic                       clk,
  input  logic                       reset,
  fetch_branch_unit_if.master        imem,
  output logic [31:0]                instr,
  output logic                       instr_valid,
  input  logic                       ex_done,
  input  logic                       isbeq,
  input  logic                       isbgt,
  input  logic                       isubranch,
  input  logic                       isret,
  input  logic                       iscall,
  input  logic                       cmp_wr,
  input  logic                       cmp_eq,
  input  logic                       cmp_gt,
  input  logic [31:0]                ra_value,
  output logic [31:0]                ra_wdata,
  output logic                       branch_taken,
  output logic [31:0]                pc,
  output logic                       flag_e,
  output logic                       flag_gt
);

  localparam int SEXT_W = 32 - OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        taken;
  logic [31:0] branch_off;
  logic [31:0] pc_plus4;
  logic [31:0] pc_nxt;
  logic        unused_call;

  // The regfile performs the ra write for calls; nothing extra to do here.
  assign unused_call = iscall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) state_nxt = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (ex_done) state_nxt = FETCH;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign imem.imem_addr = pc;
  assign pc_plus4       = pc + 32'd4;
  assign ra_wdata       = pc_plus4;
  assign branch_off     = {{SEXT_W{instr[OFFSET_W-1]}}, instr[OFFSET_W-1:0], 2'b00};

  // Decisions use the registered flags, never the compare result being written.
  assign taken        = isret | isubranch | (isbeq & flag_e) | (isbgt & flag_gt);
  assign branch_taken = instr_valid & taken;

  always_comb begin
    pc_nxt = pc_plus4;
    if (taken) begin
      if (isret) pc_nxt = ra_value;
      else       pc_nxt = pc + branch_off;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr   <= 32'h0;
      flag_e  <= 1'b0;
      flag_gt <= 1'b0;
    end else begin
      if (state == FETCH && imem.imem_ack) begin
        instr <= imem.imem_rdata;
      end
      if (state == EXEC && ex_done) begin
        pc <= pc_nxt;
        if (cmp_wr) begin
          flag_e  <= cmp_eq;
          flag_gt <= cmp_gt;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_branch_unit.sv
// tb/tb_fetch_branch_unit.sv - directed scoreboard bench for fetch_branch_unit
module tb_fetch_branch_unit;
  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_done;
  logic        isbeq, isbgt, isubranch, isret, iscall;
  logic        cmp_wr, cmp_eq, cmp_gt;
  logic [31:0] ra_value;
  logic [31:0] ra_wdata;
  logic        branch_taken;
  logic [31:0] pc;
  logic        flag_e, flag_gt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
  } exp_t;

  exp_t sb[$];

  fetch_branch_unit_if imem_bus();

  fetch_branch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (imem_bus),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .ex_done      (ex_done),
    .isbeq        (isbeq),
    .isbgt        (isbgt),
    .isubranch    (isubranch),
    .isret        (isret),
    .iscall       (iscall),
    .cmp_wr       (cmp_wr),
    .cmp_eq       (cmp_eq),
    .cmp_gt       (cmp_gt),
    .ra_value     (ra_value),
    .ra_wdata     (ra_wdata),
    .branch_taken (branch_taken),
    .pc           (pc),
    .flag_e       (flag_e),
    .flag_gt      (flag_gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [26:0] off);
    return {opc, 1'b0, off};
  endfunction

  task automatic clear_ctl();
    {isret, isubranch, isbeq, isbgt, iscall} = 5'b0;
    {cmp_wr, cmp_eq, cmp_gt} = 3'b0;
    ex_done = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (imem_bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(imem_bus.imem_req, 32'd1, {tag, " req"});
  endtask

  // ctl = {isret, isubranch, isbeq, isbgt, iscall}; cmp = {cmp_wr, cmp_eq, cmp_gt}
  task automatic run_instr(input logic [31:0] addr, input logic [31:0] rdata, input int ack_dly,
                           input logic [4:0] ctl, input logic [2:0] cmp, input logic [31:0] ra,
                           input logic [31:0] exp_pc, input logic exp_taken, input string tag);
    exp_t e;
    sb.push_back('{exp_pc, exp_taken});
    wait_req(tag);
    chk(imem_bus.imem_addr, addr, {tag, " addr"});
    // ex_done while fetching must not disturb anything
    ex_done = 1'b1;
    repeat (ack_dly) @(negedge clk);
    ex_done = 1'b0;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = rdata;
    @(negedge clk);
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'hdead_beef;
    chk(instr_valid, 32'd1, {tag, " valid"});
    chk(instr, rdata, {tag, " instr"});
    chk(imem_bus.imem_req, 32'd0, {tag, " req_exec"});
    chk(pc, addr, {tag, " pc_hold"});
    {isret, isubranch, isbeq, isbgt, iscall} = ctl;
    {cmp_wr, cmp_eq, cmp_gt} = cmp;
    ra_value = ra;
    ex_done  = 1'b1;
    #1;
    e = sb.pop_front();
    chk(branch_taken, {31'd0, e.taken}, {tag, " taken"});
    chk(ra_wdata, addr + 32'd4, {tag, " ra_wdata"});
    @(negedge clk);
    clear_ctl();
    chk(pc, e.pc, {tag, " pc"});
    chk(instr_valid, 32'd0, {tag, " valid_off"});
  endtask

  initial begin
    reset = 1'b1;
    clear_ctl();
    ra_value = 32'h0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk(pc, 32'h0, "rst pc");
    chk(instr, 32'h0, "rst instr");
    chk(imem_bus.imem_req, 32'd0, "rst req");
    chk(instr_valid, 32'd0, "rst valid");
    chk({flag_e, flag_gt}, 32'd0, "rst flags");
    reset = 1'b0;

    run_instr(32'h0, 32'h0, 2, 5'b00000, 3'b000, 32'h0, 32'h4, 1'b0, "t1 add");
    run_instr(32'h4, mk(5'd3, 27'd0), 0, 5'b00000, 3'b110, 32'h0, 32'h8, 1'b0, "t2 cmp");
    chk({flag_e, flag_gt}, 32'b10, "t2 flags");
    run_instr(32'h8, mk(5'd9, 27'd3), 1, 5'b00100, 3'b101, 32'h0, 32'h14, 1'b1, "t2 beq");
    chk({flag_e, flag_gt}, 32'b01, "t2 flags_upd");
    run_instr(32'h14, mk(5'd9, 27'd3), 0, 5'b00100, 3'b000, 32'h0, 32'h18, 1'b0, "t3 beq_nt");
    run_instr(32'h18, mk(5'd8, 27'h7FFFFFE), 0, 5'b01000, 3'b000, 32'h0, 32'h10, 1'b1, "t3 b_back");
    run_instr(32'h10, mk(5'd10, 27'h7FFFFFE), 1, 5'b00010, 3'b000, 32'h0, 32'h08, 1'b1, "t3 bgt");
    run_instr(32'h08, mk(5'd8, 27'd6), 0, 5'b01000, 3'b000, 32'h0, 32'h20, 1'b1, "t4 b");
    run_instr(32'h20, mk(5'd11, 27'h10), 0, 5'b01001, 3'b000, 32'h0, 32'h60, 1'b1, "t4 call");
    run_instr(32'h60, mk(5'd12, 27'd5), 0, 5'b11000, 3'b000, 32'h100, 32'h100, 1'b1, "t4 ret");

    wait_req("t5 pre");
    chk(imem_bus.imem_addr, 32'h100, "t5 addr");
    #2 reset = 1'b1;
    #1;
    chk(imem_bus.imem_req, 32'd0, "t5 req_drop");
    chk(pc, 32'h0, "t5 pc_rst");
    chk({flag_e, flag_gt}, 32'd0, "t5 flags_rst");
    @(negedge clk);
    reset = 1'b0;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    chk(imem_bus.imem_req, 32'd1, "t5 req_again");
    chk(instr, 32'h0, "t5 late_ack");
    chk(instr_valid, 32'd0, "t5 valid");

    run_instr(32'h0, mk(5'd10, 27'd5), 0, 5'b00010, 3'b000, 32'h0, 32'h4, 1'b0, "t5 bgt_nt");
    run_instr(32'h4, mk(5'd12, 27'd0), 1, 5'b11000, 3'b000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, "t6 ret");
    run_instr(32'hFFFF_FFFC, mk(5'd8, 27'd1), 0, 5'b01000, 3'b000, 32'h0, 32'h0, 1'b1, "t6 b_wrap");
    run_instr(32'h0, mk(5'd12, 27'd0), 0, 5'b11000, 3'b000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, "t6 ret2");
    run_instr(32'hFFFF_FFFC, mk(5'd1, 27'd0), 0, 5'b00000, 3'b000, 32'h0, 32'h0, 1'b0, "t6 nop_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
